// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller beside ID: load-use stalls, data-memory wait states and
// taken-branch flushes, plus a sticky memory timeout flag and a saturating stall counter.
module hazard_stall_unit #(
    parameter int REG_AW   = 3,
    parameter int CNT_W    = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ID_Reg_Rs,
    input  logic [REG_AW-1:0] ID_Reg_Rt,
    input  logic              ID_uses_Rt,
    input  logic              ID_valid_in,
    input  logic              EX_Mem_read,
    input  logic [REG_AW-1:0] EX_Reg_Rd,
    input  logic              EX_valid_in,
    input  logic              EXM_Mem_access,
    input  logic              EXM_valid_in,
    input  logic              mem_ready,
    input  logic              branch_taken,
    output logic              PC_write,
    output logic              IFID_write,
    output logic              IFID_flush,
    output logic              IDEX_bubble,
    output logic              EXM_hold,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exm_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_PASS  = 5'b11000;
    localparam ctrl_t CTRL_FLUSH = 5'b11110;
    localparam ctrl_t CTRL_LU    = 5'b00010;
    localparam ctrl_t CTRL_HOLD  = 5'b00001;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    ctrl_t             ctrl;
    logic              rs_hit, rt_hit, lu, mwait, tmo_set;

    assign rs_hit = (ID_Reg_Rs == EX_Reg_Rd);
    assign rt_hit = ID_uses_Rt & (ID_Reg_Rt == EX_Reg_Rd);
    assign lu     = EX_Mem_read & ~EX_valid_in & ~ID_valid_in & (rs_hit | rt_hit);
    assign mwait  = EXM_Mem_access & ~EXM_valid_in & ~mem_ready;

    // Priority mwait > branch > lu. Once a memory wait releases, the cycle is
    // decoded exactly as RUN; LU_STALL masks lu because the load has moved to MEM.
    always_comb begin
        ctrl      = CTRL_PASS;
        state_nxt = RUN;
        wait_nxt  = '0;
        unique case (state)
            MEM_WAIT: begin
                if (mwait) begin
                    ctrl      = CTRL_HOLD;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
                end else if (branch_taken) begin
                    ctrl = CTRL_FLUSH;
                end else if (lu) begin
                    ctrl      = CTRL_LU;
                    state_nxt = LU_STALL;
                end
            end
            LU_STALL: begin
                if (mwait) begin
                    ctrl      = CTRL_HOLD;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else if (branch_taken) begin
                    ctrl = CTRL_FLUSH;
                end
            end
            default: begin
                if (mwait) begin
                    ctrl      = CTRL_HOLD;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else if (branch_taken) begin
                    ctrl = CTRL_FLUSH;
                end else if (lu) begin
                    ctrl      = CTRL_LU;
                    state_nxt = LU_STALL;
                end
            end
        endcase
    end

    // wait_cnt holds the number of stalled memory cycles already completed.
    assign tmo_set = (state_nxt == MEM_WAIT) && (wait_nxt >= WAIT_MAX);

    // Reset forces a clean pass-through so no stall leaks out of reset.
    assign PC_write    = rst_n ? ctrl.pc_write    : 1'b1;
    assign IFID_write  = rst_n ? ctrl.ifid_write  : 1'b1;
    assign IFID_flush  = rst_n ? ctrl.ifid_flush  : 1'b0;
    assign IDEX_bubble = rst_n ? ctrl.idex_bubble : 1'b0;
    assign EXM_hold    = rst_n ? ctrl.exm_hold    : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (tmo_set)
                mem_timeout <= 1'b1;
            if (!PC_write && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: stimulus pushes expected controls into a
// scoreboard queue, a negedge monitor pops and compares.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ID_Reg_Rs = '0, ID_Reg_Rt = '0, EX_Reg_Rd = '0;
    logic       ID_uses_Rt = 1'b0, ID_valid_in = 1'b0, EX_Mem_read = 1'b0, EX_valid_in = 1'b0;
    logic       EXM_Mem_access = 1'b0, EXM_valid_in = 1'b0, mem_ready = 1'b1, branch_taken = 1'b0;
    logic       PC_write, IFID_write, IFID_flush, IDEX_bubble, EXM_hold, mem_timeout;
    logic [7:0] stall_count;

    hazard_stall_unit #(.REG_AW(3), .CNT_W(8), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Reg_Rs(ID_Reg_Rs), .ID_Reg_Rt(ID_Reg_Rt), .ID_uses_Rt(ID_uses_Rt),
        .ID_valid_in(ID_valid_in), .EX_Mem_read(EX_Mem_read), .EX_Reg_Rd(EX_Reg_Rd),
        .EX_valid_in(EX_valid_in), .EXM_Mem_access(EXM_Mem_access),
        .EXM_valid_in(EXM_valid_in), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
        .IDEX_bubble(IDEX_bubble), .EXM_hold(EXM_hold), .mem_timeout(mem_timeout),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urt;
        logic       idv;
        logic       exmr;
        logic [2:0] exrd;
        logic       exv;
        logic       exma;
        logic       exmv;
        logic       mrdy;
        logic       br;
    } stim_t;

    // {PC_write, IFID_write, IFID_flush, IDEX_bubble, EXM_hold}
    typedef struct packed {
        logic [4:0] ctrl;
        logic       tmo;
        logic [7:0] cnt;
    } exp_t;

    localparam logic [4:0] P = 5'b11000;
    localparam logic [4:0] F = 5'b11110;
    localparam logic [4:0] L = 5'b00010;
    localparam logic [4:0] H = 5'b00001;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1; s.rs = 3'd1; s.rt = 3'd2; s.urt = 1'b1; s.mrdy = 1'b1;
        return s;
    endfunction

    function automatic stim_t ld(input logic [2:0] rd);
        stim_t s;
        s = idle();
        s.exmr = 1'b1; s.exrd = rd;
        return s;
    endfunction

    task automatic cyc(input string nm, input stim_t s, input logic [4:0] c,
                       input logic t, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; ID_Reg_Rs = s.rs; ID_Reg_Rt = s.rt; ID_uses_Rt = s.urt;
        ID_valid_in = s.idv; EX_Mem_read = s.exmr; EX_Reg_Rd = s.exrd; EX_valid_in = s.exv;
        EXM_Mem_access = s.exma; EXM_valid_in = s.exmv; mem_ready = s.mrdy; branch_taken = s.br;
        e.ctrl = c; e.tmo = t; e.cnt = 8'(cnt);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        exp_t  g;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g.ctrl = {PC_write, IFID_write, IFID_flush, IDEX_bubble, EXM_hold};
            g.tmo  = mem_timeout;
            g.cnt  = stall_count;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s: got ctrl=%b tmo=%b cnt=%0d, want ctrl=%b tmo=%b cnt=%0d",
                         nm, g.ctrl, g.tmo, g.cnt, e.ctrl, e.tmo, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        s = ld(3'd3); s.rs = 3'd3; s.rst_n = 1'b0;
        cyc("rst_lu", s, P, 1'b0, 0);
        s = idle(); s.rst_n = 1'b0; s.exma = 1'b1; s.mrdy = 1'b0;
        cyc("rst_mwait", s, P, 1'b0, 0);
        s = idle();
        cyc("idle0", s, P, 1'b0, 0);

        s = ld(3'd3); s.rs = 3'd3;
        cyc("lu_rs", s, L, 1'b0, 0);
        cyc("lu_stall_masks_lu", s, P, 1'b0, 1);
        s = idle();
        cyc("after_lu", s, P, 1'b0, 1);
        s = ld(3'd3); s.rt = 3'd3; s.urt = 1'b0;
        cyc("rt_unused", s, P, 1'b0, 1);
        s.urt = 1'b1;
        cyc("lu_rt", s, L, 1'b0, 1);
        s = idle();
        cyc("after_lu_rt", s, P, 1'b0, 2);
        s = ld(3'd3); s.rs = 3'd3; s.exv = 1'b1;
        cyc("ex_bubble", s, P, 1'b0, 2);
        s.exv = 1'b0; s.idv = 1'b1;
        cyc("id_bubble", s, P, 1'b0, 2);
        s.idv = 1'b0; s.br = 1'b1;
        cyc("lu_and_br", s, F, 1'b0, 2);
        s.br = 1'b0;
        cyc("lu_after_br", s, L, 1'b0, 2);
        s = idle();
        cyc("ret_run", s, P, 1'b0, 3);
        s.br = 1'b1;
        cyc("br", s, F, 1'b0, 3);

        s = idle(); s.exma = 1'b1; s.mrdy = 1'b0;
        cyc("mw1", s, H, 1'b0, 3);
        s.br = 1'b1;
        cyc("mw2_br_ignored", s, H, 1'b0, 4);
        s.br = 1'b0;
        cyc("mw3", s, H, 1'b0, 5);
        cyc("mw4", s, H, 1'b0, 6);
        s.mrdy = 1'b1; s.br = 1'b1;
        cyc("mw_release_br", s, F, 1'b0, 7);
        s = idle(); s.exma = 1'b1; s.exmv = 1'b1; s.mrdy = 1'b0;
        cyc("exm_bubble", s, P, 1'b0, 7);

        s.exmv = 1'b0;
        for (int i = 1; i <= 16; i++)
            cyc("tmo_wait", s, H, (i == 16), 7 + i - 1);
        s = idle();
        cyc("tmo_sticky", s, P, 1'b1, 23);
        cyc("tmo_sticky2", s, P, 1'b1, 23);

        s.exma = 1'b1; s.mrdy = 1'b0;
        for (int i = 1; i <= 300; i++)
            cyc("sat", s, H, 1'b1, (23 + i - 1 > 255) ? 255 : 23 + i - 1);
        s = idle();
        cyc("sat_release", s, P, 1'b1, 255);

        s.exma = 1'b1; s.mrdy = 1'b0;
        cyc("mw_pre_rst", s, H, 1'b1, 255);
        s.rst_n = 1'b0;
        cyc("rst_in_mw", s, P, 1'b1, 255);
        s = ld(3'd3); s.rs = 3'd3;
        cyc("post_rst_lu", s, L, 1'b0, 0);
        s = idle();
        cyc("post_rst_idle", s, P, 1'b0, 1);

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
